// File: rtl/ofdm_tx_cmd_sched.sv
// Command scheduler in front of the OFDM TX core: arbitrates host FIFO commands
// against periodic beacon commands, gates host commands on data availability
// and enforces a programmable idle gap after every accepted command.
module ofdm_tx_cmd_sched #(
  parameter int unsigned GAP_W  = 16,
  parameter int unsigned PER_W  = 24,
  parameter int unsigned DCNT_W = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sched_enable,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic              beacon_enable,
  input  logic [PER_W-1:0]  beacon_period,
  input  logic [31:0]       beacon_cmd,
  input  logic              host_cmd_empty,
  input  logic [31:0]       host_cmd_data,
  output logic              host_cmd_rd,
  input  logic [DCNT_W-1:0] dataq_count,
  output logic              tx_cmd_valid,
  input  logic              tx_cmd_ready,
  output logic [31:0]       tx_cmd_bits,
  output logic              tx_cmd_src,
  output logic              sched_busy,
  output logic [15:0]       beacon_miss_cnt
);

  localparam int unsigned CMP_W = (DCNT_W > 8) ? DCNT_W : 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [GAP_W-1:0]  r_gap;
  logic [PER_W-1:0]  r_bcnt;
  logic              r_pend;
  logic [15:0]       r_miss;
  logic [31:0]       r_bits;
  logic              r_src;

  logic              w_bon, w_tick, w_bclr, w_host_elig, w_grant, w_hs;
  logic [CMP_W-1:0]  w_dcnt_ext, w_len_ext;

  assign w_bon       = beacon_enable && (beacon_period != '0);
  assign w_tick      = w_bon && (r_bcnt == '0);
  assign w_bclr      = w_hs && r_src;
  assign w_dcnt_ext  = CMP_W'(dataq_count);
  assign w_len_ext   = CMP_W'(host_cmd_data[7:0]);
  assign w_host_elig = !host_cmd_empty && (w_dcnt_ext >= w_len_ext);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_hs         = 1'b0;
    tx_cmd_valid = 1'b0;
    host_cmd_rd  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (sched_enable && (r_pend || w_host_elig)) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tx_cmd_valid = 1'b1;
        if (tx_cmd_ready) begin
          w_hs        = 1'b1;
          host_cmd_rd = !r_src && !host_cmd_empty;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bits <= '0;
      r_src  <= 1'b0;
      r_gap  <= '0;
    end else begin
      if (w_grant) begin
        r_bits <= r_pend ? beacon_cmd : host_cmd_data;
        r_src  <= r_pend;
      end
      if (w_hs)                                    r_gap <= gap_cycles;
      else if (r_state == S_GAP && r_gap != '0)    r_gap <= r_gap - 1'b1;
    end
  end

  // A tick coinciding with the beacon handshake re-arms the pend without a miss.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bcnt <= '0;
      r_pend <= 1'b0;
      r_miss <= '0;
    end else if (!w_bon) begin
      r_bcnt <= '0;
      r_pend <= 1'b0;
    end else begin
      if (r_bcnt == '0) r_bcnt <= beacon_period - 1'b1;
      else              r_bcnt <= r_bcnt - 1'b1;
      if (w_tick) begin
        if (r_pend && !w_bclr && r_miss != '1) r_miss <= r_miss + 1'b1;
        r_pend <= 1'b1;
      end else if (w_bclr) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign tx_cmd_bits     = r_bits;
  assign tx_cmd_src      = r_src;
  assign sched_busy      = (r_state != S_IDLE);
  assign beacon_miss_cnt = r_miss;

endmodule

// File: tb/tb_ofdm_tx_cmd_sched.sv
// Bench for ofdm_tx_cmd_sched: directed scenarios followed by random traffic,
// all checked against a cycle-indexed behavioural model of the scheduler.
module tb_ofdm_tx_cmd_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sched_enable = 1'b0;
  logic [15:0] gap_cycles = '0;
  logic        beacon_enable = 1'b0;
  logic [23:0] beacon_period = '0;
  logic [31:0] beacon_cmd = 32'hBEAC0000;
  logic        host_cmd_empty = 1'b1;
  logic [31:0] host_cmd_data = '0;
  logic [9:0]  dataq_count = '0;
  logic        tx_cmd_ready = 1'b0;
  logic        host_cmd_rd, tx_cmd_valid, tx_cmd_src, sched_busy;
  logic [31:0] tx_cmd_bits;
  logic [15:0] beacon_miss_cnt;

  ofdm_tx_cmd_sched #(.GAP_W(16), .PER_W(24), .DCNT_W(10)) dut (
    .clk(clk), .rstn(rstn), .sched_enable(sched_enable), .gap_cycles(gap_cycles),
    .beacon_enable(beacon_enable), .beacon_period(beacon_period), .beacon_cmd(beacon_cmd),
    .host_cmd_empty(host_cmd_empty), .host_cmd_data(host_cmd_data), .host_cmd_rd(host_cmd_rd),
    .dataq_count(dataq_count), .tx_cmd_valid(tx_cmd_valid), .tx_cmd_ready(tx_cmd_ready),
    .tx_cmd_bits(tx_cmd_bits), .tx_cmd_src(tx_cmd_src), .sched_busy(sched_busy),
    .beacon_miss_cnt(beacon_miss_cnt)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  logic [31:0] hq[$];
  bit          pop_seen = 1'b0;
  int          vstart[$];
  bit          prev_valid = 1'b0;

  task automatic sync_host();
    host_cmd_empty = (hq.size() == 0);
    host_cmd_data  = host_cmd_empty ? 32'h0 : hq[0];
  endtask

  task automatic push(input logic [31:0] w);
    hq.push_back(w);
    sync_host();
  endtask

  task automatic step(input int n);
    logic [31:0] dummy;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pop_seen) begin
        dummy    = hq.pop_front();
        pop_seen = 1'b0;
      end
      sync_host();
    end
  endtask

  // Model: grants are allowed from cycle m_next onward; beacons tick every
  // beacon_period cycles counted from the first enabled cycle.
  bit          m_valid, m_src, m_pend, m_bprev;
  logic [31:0] m_word;
  int          m_next, cyc, m_miss, m_base;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid = 0; m_src = 0; m_pend = 0; m_bprev = 0; m_word = '0;
      m_next = 0; cyc = 0; m_miss = 0; m_base = 0;
    end else begin : upd
      bit bon, tick, hs, elig, grant, pend_old;
      bon = beacon_enable && (beacon_period != 0);
      if (bon && !m_bprev) m_base = cyc;
      tick = bon && (((cyc - m_base) % int'(beacon_period)) == 0);
      hs   = m_valid && tx_cmd_ready;
      elig = !host_cmd_empty && (int'(dataq_count) >= int'(host_cmd_data[7:0]));
      pend_old = m_pend;
      grant = !m_valid && (cyc >= m_next) && sched_enable && (pend_old || elig);
      if (!bon) m_pend = 0;
      else if (tick) begin
        if (m_pend && !(hs && m_src) && m_miss < 65535) m_miss++;
        m_pend = 1;
      end else if (hs && m_src) m_pend = 0;
      if (hs) begin
        m_valid = 0;
        m_next  = cyc + int'(gap_cycles) + 2;
      end
      if (grant) begin
        m_valid = 1;
        m_src   = pend_old;
        m_word  = pend_old ? beacon_cmd : host_cmd_data;
      end
      m_bprev = bon;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      chk("valid", {31'b0, tx_cmd_valid}, {31'b0, m_valid});
      if (m_valid) begin
        chk("bits", tx_cmd_bits, m_word);
        chk("src", {31'b0, tx_cmd_src}, {31'b0, m_src});
      end
      chk("rd", {31'b0, host_cmd_rd},
          {31'b0, m_valid && tx_cmd_ready && !m_src && !host_cmd_empty});
      chk("busy", {31'b0, sched_busy}, {31'b0, m_valid || (cyc < m_next)});
      chk("miss", {16'b0, beacon_miss_cnt}, m_miss);
      pop_seen = host_cmd_rd;
      if (tx_cmd_valid && !prev_valid) vstart.push_back(cyc);
      prev_valid = tx_cmd_valid;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {31'b0, tx_cmd_valid}, 32'h0);
    chk({tag, "_rd"},    {31'b0, host_cmd_rd}, 32'h0);
    chk({tag, "_busy"},  {31'b0, sched_busy}, 32'h0);
    chk({tag, "_src"},   {31'b0, tx_cmd_src}, 32'h0);
    chk({tag, "_bits"},  tx_cmd_bits, 32'h0);
    chk({tag, "_miss"},  {16'b0, beacon_miss_cnt}, 32'h0);
  endtask

  task automatic do_reset();
    #2;
    rstn = 1'b0;
    pop_seen = 1'b0;
    #1;
    check_all_zero("rst");
    step(2);
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    int c, qs;
    #1;
    check_all_zero("por");
    step(2);
    #2 rstn = 1'b1;

    // Host only: two back-to-back eligible words, gap of 4.
    step(1);
    gap_cycles = 16'd4; tx_cmd_ready = 1'b1; sched_enable = 1'b1; dataq_count = 10'd16;
    vstart.delete();
    c = cyc;
    push(32'h0000_0010);
    push(32'h0000_0110);
    step(20);
    chk("host_first", vstart.size() > 0 ? vstart[0] : -1, c + 1);
    chk("host_space", vstart.size() > 1 ? vstart[1] - vstart[0] : -1, 7);
    chk("host_drain", hq.size(), 0);

    // Data gating on the command length.
    dataq_count = 10'd31;
    push(32'h0000_0020);
    step(10);
    chk("gate_hold", {31'b0, tx_cmd_valid}, 32'h0);
    dataq_count = 10'd32;
    step(1);
    chk("gate_go", {31'b0, tx_cmd_valid}, 32'h1);
    step(10);

    // Backpressure with a 10-cycle beacon: five expiries, four misses.
    do_reset();
    step(1);
    tx_cmd_ready = 1'b0; gap_cycles = 16'd0; dataq_count = 10'd0;
    push(32'h5A00_0000);
    beacon_period = 24'd10; beacon_enable = 1'b1;
    qs = hq.size();
    step(50);
    chk("bp_miss", {16'b0, beacon_miss_cnt}, 32'd4);
    chk("bp_nopop", hq.size(), qs);
    tx_cmd_ready = 1'b1;
    step(30);
    beacon_enable = 1'b0;
    step(5);

    // Enable drop during ISSUE.
    tx_cmd_ready = 1'b0;
    push(32'h1111_0000);
    push(32'h2222_0000);
    step(3);
    sched_enable = 1'b0;
    step(3);
    chk("drop_hold", {31'b0, tx_cmd_valid}, 32'h1);
    tx_cmd_ready = 1'b1;
    step(30);
    chk("drop_idle", {31'b0, sched_busy}, 32'h0);
    chk("drop_q", hq.size(), 1);

    // Async reset with a command in flight.
    tx_cmd_ready = 1'b0; sched_enable = 1'b1;
    step(3);
    chk("ar_issue", {31'b0, tx_cmd_valid}, 32'h1);
    qs = hq.size();
    do_reset();
    chk("ar_nopop", hq.size(), qs);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) begin
        beacon_enable = 1'b0;
        step(1);
        beacon_period = 24'($urandom_range(3, 30));
        beacon_cmd    = $urandom;
        beacon_enable = ($urandom % 4) != 0;
      end
      tx_cmd_ready = ($urandom % 4) != 0;
      sched_enable = ($urandom % 16) != 0;
      dataq_count  = 10'($urandom % 48);
      gap_cycles   = 16'($urandom % 4);
      if (($urandom % 6) == 0 && hq.size() < 8)
        push({24'($urandom), 8'($urandom % 40)});
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ofdm_tx_cmd_sched.md
Name: ofdm_tx_cmd_sched

Overview:
- Schedules commands into the OFDM TX core's command port (cmd valid/ready, 32-bit command word).
- Two requesters share the port:
  - Host commands popped from the first-word-fall-through (FWFT) command FIFO.
  - Internally timed beacon commands.
- Enforces data availability, beacon priority and a programmable inter-command gap.
- Sits in the sample-clock domain between the command/data FIFOs and the TX core.

Parameters:
- GAP_W, 16, width of the inter-command gap counter.
- PER_W, 24, width of the beacon period counter.
- DCNT_W, 10, width of the data-FIFO read count input.

Ports:
- clk  in  1  sample clock; all logic is rising-edge.
- rstn  in  1  asynchronous active-low reset.
- sched_enable  in  1  level; allows new grants.
- gap_cycles  in  GAP_W  idle cycles inserted after each accepted command.
- beacon_enable  in  1  level; runs the beacon timer.
- beacon_period  in  PER_W  beacon interval in cycles; 0 disables beacons.
- beacon_cmd  in  32  command word issued for a beacon.
- host_cmd_empty  in  1  host command FIFO empty.
- host_cmd_data  in  32  FWFT head of the host command FIFO.
- host_cmd_rd  out  1  single-cycle pop strobe.
- dataq_count  in  DCNT_W  data-FIFO read count.
- tx_cmd_valid  out  1  command valid to the TX core.
- tx_cmd_ready  in  1  TX core ready.
- tx_cmd_bits  out  32  command word {pause[31:24], repeat[23:17], seed[16:10], mode[9:8], length[7:0]}.
- tx_cmd_src  out  1  source of the current command: 0 = host, 1 = beacon.
- sched_busy  out  1  high when state is not IDLE.
- beacon_miss_cnt  out  16  saturating count of dropped beacon ticks.

Behaviour:
- Reset values (async, rstn low):
  - state = IDLE.
  - All outputs 0.
  - Beacon counter = 0.
  - beacon_pend = 0.
- Beacon timer (when beacon_enable=1 and beacon_period!=0):
  - The counter decrements every cycle.
  - At 0 it reloads beacon_period-1 and sets beacon_pend.
  - If beacon_pend is already set at expiry, beacon_miss_cnt increments, saturating at 0xFFFF. The pend stays set and only one beacon is kept.
  - When the timer is disabled, the counter holds 0 and beacon_pend clears. On re-enable, the first tick occurs 1 cycle later.
- Host eligibility: host_cmd_empty=0 and dataq_count >= host_cmd_data[7:0]. Compare zero-extended; length 0 is always eligible.
- Beacon eligibility: beacon_pend=1.
- State IDLE:
  - If sched_enable=1 and any requester is eligible, latch the word and src and go to ISSUE.
  - Beacon wins when both are eligible.
  - The grant decision in cycle n gives tx_cmd_valid=1 in cycle n+1.
- State ISSUE:
  - tx_cmd_valid=1; tx_cmd_bits and tx_cmd_src are held stable until the handshake.
  - On tx_cmd_valid & tx_cmd_ready:
    - host_cmd_rd pulses in the same cycle if src=host.
    - beacon_pend clears in the same cycle if src=beacon. A tick arriving in that same cycle re-sets the pend and is not counted as a miss.
    - Load the gap counter with gap_cycles and go to GAP.
  - Deasserting sched_enable does not withdraw a valid command; ISSUE completes.
- State GAP:
  - Counts down to 0, then goes to IDLE.
  - gap_cycles=0 means one cycle in GAP, so the minimum spacing is 3 cycles handshake-to-valid.
  - gap_cycles is sampled only at the handshake.
- Pop discipline:
  - host_cmd_rd is never asserted when host_cmd_empty=1.
  - At most one pop per accepted host command.
  - A host word that changes in IDLE before a grant is simply re-evaluated.
- Mid-operation reset (rstn low): returns to IDLE immediately. No pop occurs and the in-flight command is dropped.
- sched_busy = (state != IDLE).

Test Plan:
- Host only:
  - Stimulus: host_cmd_data=0x0000_0010, dataq_count=16, gap_cycles=4, tx_cmd_ready=1.
  - Required: tx_cmd_valid high 1 cycle after eligibility; host_cmd_rd 1 pulse; next valid no earlier than 7 cycles later.
- Data gating:
  - Stimulus: length=0x20 with dataq_count=31.
  - Required: no valid. Raise dataq_count to 32 → valid issued 1 cycle later.
- Beacon priority:
  - Stimulus: beacon_period=100, host always eligible.
  - Required: every ~100 cycles tx_cmd_src=1 and tx_cmd_bits=beacon_cmd; host_cmd_rd never pulses on beacon handshakes.
- Backpressure:
  - Stimulus: tx_cmd_ready=0 for 50 cycles.
  - Required: tx_cmd_bits stable; with beacon_period=10, beacon_miss_cnt=4 (expiries at 10/20/30/40/50, first sets pend); host_cmd_rd stays 0 until ready.
- Enable drop:
  - Stimulus: deassert sched_enable during ISSUE.
  - Required: command still completes; no further grant afterward.
- Async reset:
  - Stimulus: rstn low during ISSUE.
  - Required: all outputs 0 immediately; miss count 0; no pop.
